cle_key_seq: RTL
================

// Module: cle_key_seq
// PURPOSE
//  Bus-mapped challenge/response key sequencer, parametrised successor of the fixed 6-bit keyed GAL state machine.
//  Host reads inside an address window must present addr[7:4] nibbles matching an internal LFSR sequence.
//  After KEY_LEN consecutive matches the block opens and returns LFSR-derived response bits on each window read.
//  Sits on the local CPU bus beside the ROM decode; its data output shares the bus through dout_oe.
// PARAMETERS
//  ADDR_W   14        bus address width
//  BASE     14'h1000  window base, compared under MASK
//  MASK     14'h3000  address bits that take part in the window compare
//  STATE_W  6         LFSR width (>=4)
//  TAPS     6'h30     Fibonacci feedback tap mask (x^6+x^5+1)
//  SEED     6'h01     reload value; a zero value is forced to 1
//  KEY_LEN  4         correct accesses required to open (1..15)
//  OUT_W    2         response width (<=STATE_W)
//  MAX_FAIL 3         mismatches before lockout (CLE_SEQ_LOCKOUT_EN only)
// PORTS
//  clk      in   1        bus-synchronous clock
//  rst_n    in   1        asynchronous active-low reset
//  sel_n    in   1        active-low bus select (SSER equivalent)
//  addr     in   ADDR_W   bus address
//  rd       in   1        1 = read, 0 = write (BR_W)
//  dout     out  OUT_W    response data, registered
//  dout_oe  out  1        drive enable for dout onto the bus
//  is_open  out  1        status: mode == OPEN
// BEHAVIOUR
//  - hit = !sel_n & ((addr & MASK) == BASE). hit_q is the registered hit.
//  - An access pulse acc = hit & !hit_q fires once per bus cycle. Holding hit high never re-triggers.
//  - Modes: LOCKED (step counter 0..KEY_LEN-1) and OPEN. Reset: LOCKED, step=0, state=SEED, dout=0, hit_q=0.
//  - lfsr_next(s) = {s[STATE_W-2:0], ^(s & TAPS)}.
//  - LOCKED, acc & rd:
//      addr[7:4]==state[3:0] -> state<=next and step++. When step==KEY_LEN-1 -> OPEN, step<=0.
//      any other nibble -> step<=0 and state<=SEED.
//  - OPEN, acc & rd: dout <= state[STATE_W-1 -: OUT_W] and state <= next, in the same edge.
//  - acc & !rd (write), any mode: relock. Mode LOCKED, step 0, state SEED, dout 0. Relock takes priority.
//  - dout_oe = hit & hit_q & rd & (mode==OPEN). It is high from the cycle after acc until hit drops. It is 0 in LOCKED.
//  - is_open is registered and equals (mode==OPEN).
//  - Reset mid-access: everything returns to reset values immediately. A hit still held after reset release gives
//    one new acc pulse, because hit_q resets to 0.
//  - The step counter is $clog2(KEY_LEN+1) bits wide and never wraps past KEY_LEN-1.
// CONFIGURATION
//  CLE_SEQ_LOCKOUT_EN defined:
//    - A fail counter counts consecutive mismatches and clears on any match.
//    - At MAX_FAIL the block enters LOCKOUT: no opening and dout_oe=0.
//    - Writes do not leave LOCKOUT; only rst_n does.
//  CLE_SEQ_LOCKOUT_EN undefined: a mismatch only restarts the sequence. The LOCKOUT state and the fail counter are absent.
// STRUCTURE
//  - cle_seq_pkg holds:
//      mode_t enum (LOCKED, OPEN, LOCKOUT)
//      function lfsr_next(state, taps)
//      function seed_fix (zero -> 1)
//  - Sub-module cle_seq_lfsr holds the state register with load/step inputs and exposes state.
//    Its parameters are STATE_W, TAPS and SEED.
//  - The top level holds window decode, edge detect, mode FSM and output regs.
// TESTING (defaults)
//  1. Reset, then reads at addr[7:4]=1,2,4,8 (addr 0x1010,0x1020,0x1040,0x1080) -> is_open=1, state=6'h10.
//  2. Open, three reads -> dout=2'b01, 2'b10, 2'b00 (states 10,21,03). dout_oe=0 on the acc cycle, 1 after.
//  3. Locked, reads at nibbles 1,2,then 7 -> step=0 and state=6'h01. Following 1,2,4,8 -> opens.
//  4. Open, write anywhere in the window -> is_open=0 next cycle and dout_oe=0. A read with sel_n=1 or addr 0x0010
//     -> no state change.
//  5. hit held 10 cycles -> exactly one step. rst_n pulsed low mid-hit -> reset values, then one acc after release.
//  6. With CLE_SEQ_LOCKOUT_EN, three wrong nibbles -> LOCKOUT. Correct sequence and writes are ignored.
//     rst_n recovers. Without the macro, the same stimulus followed by the correct sequence opens.

Source files
------------

// File: rtl/cle_seq_pkg.sv
// Shared types and LFSR helpers for the challenge/response key sequencer.
// Pure functions, no state; no flow control.
package cle_seq_pkg;

  typedef enum logic [1:0] {
    LOCKED  = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } mode_t;

  localparam int unsigned LFSR_MAX_W = 32;

  function automatic logic [LFSR_MAX_W-1:0] width_mask(input int unsigned w);
    return (w >= LFSR_MAX_W) ? '1 : ((32'd1 << w) - 32'd1);
  endfunction

  // Fibonacci step: shift left, feedback parity of tapped bits enters at bit 0.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(input logic [LFSR_MAX_W-1:0] state,
                                                      input logic [LFSR_MAX_W-1:0] taps,
                                                      input int unsigned           w);
    return ((state << 1) | {31'd0, ^(state & taps)}) & width_mask(w);
  endfunction

  function automatic logic [LFSR_MAX_W-1:0] seed_fix(input logic [LFSR_MAX_W-1:0] seed,
                                                     input int unsigned           w);
    logic [LFSR_MAX_W-1:0] m;
    m = seed & width_mask(w);
    return (m == '0) ? 32'd1 : m;
  endfunction

endpackage

// File: rtl/cle_seq_lfsr.sv
// LFSR state register with synchronous reload (priority) and step; one cycle per update.
// No flow control: load/step are single-cycle strobes from the owning FSM.
module cle_seq_lfsr
  import cle_seq_pkg::*;
#(
  parameter int unsigned          STATE_W = 6,
  parameter logic [STATE_W-1:0]   TAPS    = 6'h30,
  parameter logic [STATE_W-1:0]   SEED    = 6'h01
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic               i_step,
  output logic [STATE_W-1:0] o_state
);

  localparam logic [STATE_W-1:0] SEED_FIX = STATE_W'(seed_fix(32'(SEED), STATE_W));

  logic [STATE_W-1:0] r_state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= SEED_FIX;
    end else if (i_load) begin
      r_state <= SEED_FIX;
    end else if (i_step) begin
      r_state <= STATE_W'(lfsr_next(32'(r_state), 32'(TAPS), STATE_W));
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/cle_key_seq.sv
// Bus-window key sequencer: KEY_LEN matching addr[7:4] reads open it, then reads return LFSR bits (dout registered, 1 cycle).
// No backpressure; dout_oe follows the held bus access. CLE_SEQ_LOCKOUT_EN adds a fail counter and sticky LOCKOUT.
module cle_key_seq
  import cle_seq_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 14,
  parameter logic [ADDR_W-1:0]  BASE     = 14'h1000,
  parameter logic [ADDR_W-1:0]  MASK     = 14'h3000,
  parameter int unsigned        STATE_W  = 6,
  parameter logic [STATE_W-1:0] TAPS     = 6'h30,
  parameter logic [STATE_W-1:0] SEED     = 6'h01,
  parameter int unsigned        KEY_LEN  = 4,
  parameter int unsigned        OUT_W    = 2,
  parameter int unsigned        MAX_FAIL = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sel_n,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_rd,
  output logic [OUT_W-1:0]  o_dout,
  output logic              o_dout_oe,
  output logic              o_is_open
);

  localparam int unsigned STEP_W = $clog2(KEY_LEN + 1);

  if (KEY_LEN < 1 || KEY_LEN > 15 || STATE_W < 4 || OUT_W > STATE_W || ADDR_W < 8
      || MAX_FAIL < 1) begin : g_param_err
    $error("cle_key_seq: parameter out of range");
  end

  logic               w_hit;
  logic               r_hit_q;
  logic               w_acc;
  logic               w_nib_ok;
  mode_t              r_mode, w_mode_nxt;
  logic [STEP_W-1:0]  r_step, w_step_nxt;
  logic [OUT_W-1:0]   r_dout, w_dout_nxt;
  logic               w_lfsr_load, w_lfsr_step;
  logic [STATE_W-1:0] w_state;

`ifdef CLE_SEQ_LOCKOUT_EN
  localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);
  logic [FAIL_W-1:0]  r_fail, w_fail_nxt;
`endif

  assign w_hit    = !i_sel_n && ((i_addr & MASK) == BASE);
  assign w_acc    = w_hit && !r_hit_q;
  assign w_nib_ok = (i_addr[7:4] == w_state[3:0]);

  cle_seq_lfsr #(
    .STATE_W (STATE_W),
    .TAPS    (TAPS),
    .SEED    (SEED)
  ) u_lfsr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_lfsr_load),
    .i_step  (w_lfsr_step),
    .o_state (w_state)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hit_q <= 1'b0;
      r_mode  <= LOCKED;
      r_step  <= '0;
      r_dout  <= '0;
`ifdef CLE_SEQ_LOCKOUT_EN
      r_fail  <= '0;
`endif
    end else begin
      r_hit_q <= w_hit;
      r_mode  <= w_mode_nxt;
      r_step  <= w_step_nxt;
      r_dout  <= w_dout_nxt;
`ifdef CLE_SEQ_LOCKOUT_EN
      r_fail  <= w_fail_nxt;
`endif
    end
  end

  always_comb begin
    w_mode_nxt  = r_mode;
    w_step_nxt  = r_step;
    w_dout_nxt  = r_dout;
    w_lfsr_load = 1'b0;
    w_lfsr_step = 1'b0;
`ifdef CLE_SEQ_LOCKOUT_EN
    w_fail_nxt  = r_fail;
`endif
    if (w_acc) begin
      if (!i_rd) begin
        // A write relocks from any mode except the sticky lockout.
        if (r_mode != LOCKOUT) begin
          w_mode_nxt  = LOCKED;
          w_step_nxt  = '0;
          w_dout_nxt  = '0;
          w_lfsr_load = 1'b1;
        end
      end else begin
        unique case (r_mode)
          LOCKED: begin
            if (w_nib_ok) begin
              w_lfsr_step = 1'b1;
`ifdef CLE_SEQ_LOCKOUT_EN
              w_fail_nxt  = '0;
`endif
              if (r_step == STEP_W'(KEY_LEN - 1)) begin
                w_mode_nxt = OPEN;
                w_step_nxt = '0;
              end else begin
                w_step_nxt = r_step + STEP_W'(1);
              end
            end else begin
              w_step_nxt  = '0;
              w_lfsr_load = 1'b1;
`ifdef CLE_SEQ_LOCKOUT_EN
              w_fail_nxt  = r_fail + FAIL_W'(1);
              if (r_fail == FAIL_W'(MAX_FAIL - 1)) begin
                w_mode_nxt = LOCKOUT;
              end
`endif
            end
          end
          OPEN: begin
            w_dout_nxt  = w_state[STATE_W-1 -: OUT_W];
            w_lfsr_step = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_dout    = r_dout;
  assign o_dout_oe = w_hit && r_hit_q && i_rd && (r_mode == OPEN);
  assign o_is_open = (r_mode == OPEN);

endmodule
